// File: rtl/ike_pkg.sv
// Shared bike-computer constants and types used by the speed stage and the divider.
// Keeps operand/result widths in one place so both sides agree.
package ike_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_W_IN  = 26;
    localparam int DIV_W_OUT = 16;

    // Fixed-point speed scale factor consumed by the speed stage.
    localparam logic [15:0] SPEED_K = 16'b1001001_10111010;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between the speed stage (master) and the divider (slave).
// start/dividend/divisor flow in; registered quotient, remainder and status flow back.
interface seq_divider_if #(
    parameter int WIDTH_IN  = ike_pkg::DIV_W_IN,
    parameter int WIDTH_OUT = ike_pkg::DIV_W_OUT
);
    logic                 start;
    logic [WIDTH_IN-1:0]  dividend;
    logic [WIDTH_IN-1:0]  divisor;
    logic [WIDTH_OUT-1:0] quotient;
    logic [WIDTH_IN-1:0]  remainder;
    logic                 Busy;
    logic                 Ready;
    logic                 div0;
    logic                 ovf;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, Busy, Ready, div0, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, Busy, Ready, div0, ovf
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit, trial-subtract.
// The shifted value is one bit wider than the operands so the compare cannot overflow.
module div_step #(
    parameter int W = 26
) (
    input  logic [W-1:0] rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);
    logic [W:0]   shifted;
    logic [W-1:0] diff;

    assign shifted = {rem_in, bit_in};
    // When the subtraction is taken the true difference is below divisor, so W bits suffice.
    assign diff    = shifted[W-1:0] - divisor;
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? diff : shifted[W-1:0];
endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring unsigned divider, fixed WIDTH_IN-cycle latency.
// start/Busy/Ready handshake; start is ignored while iterating, Ready holds until next start.
module seq_divider
    import ike_pkg::*;
#(
    parameter int WIDTH_IN  = DIV_W_IN,
    parameter int WIDTH_OUT = DIV_W_OUT
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH_IN + 1);

    state_t               state, state_nxt;
    logic [WIDTH_IN-1:0]  dvd_sr;
    logic [WIDTH_IN-1:0]  dsr;
    logic [WIDTH_IN-1:0]  rem;
    logic [WIDTH_IN-1:0]  rem_step;
    logic [WIDTH_IN-1:0]  q_full;
    logic [CW-1:0]        cnt;
    logic                 q_bit;
    logic                 q_ovf;
    logic                 accept;
    logic                 last;

    assign accept = bus.start && (state != RUN);
    assign last   = (state == RUN) && (cnt == CW'(1));

    div_step #(.W(WIDTH_IN)) u_step (
        .rem_in  (rem),
        .bit_in  (dvd_sr[WIDTH_IN-1]),
        .divisor (dsr),
        .rem_out (rem_step),
        .q_bit   (q_bit)
    );

    // dvd_sr drains dividend bits from the top while quotient bits fill from the bottom.
    assign q_full = {dvd_sr[WIDTH_IN-2:0], q_bit};
    assign q_ovf  = |q_full[WIDTH_IN-1:WIDTH_OUT];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = RUN;
            RUN:        if (last)      state_nxt = DONE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.Busy  = (state == RUN);
        bus.Ready = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_sr        <= '0;
            dsr           <= '0;
            rem           <= '0;
            cnt           <= '0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.div0      <= 1'b0;
            bus.ovf       <= 1'b0;
        end else if (accept) begin
            dvd_sr   <= bus.dividend;
            dsr      <= bus.divisor;
            rem      <= '0;
            cnt      <= CW'(WIDTH_IN);
            bus.div0 <= 1'b0;
            bus.ovf  <= 1'b0;
        end else if (state == RUN) begin
            dvd_sr <= q_full;
            rem    <= rem_step;
            cnt    <= cnt - CW'(1);
            if (last) begin
                bus.quotient  <= q_ovf ? '1 : q_full[WIDTH_OUT-1:0];
                bus.remainder <= rem_step;
                bus.div0      <= (dsr == '0);
                bus.ovf       <= q_ovf;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Randomized scoreboard bench for seq_divider against a plain-arithmetic division model.
module tb_seq_divider;
    localparam int WI = 26;
    localparam int WO = 16;
    localparam int LAT = WI;

    typedef struct {
        logic [WO-1:0] q;
        logic [WI-1:0] r;
        bit            d0;
        bit            ov;
        int            rcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   ncmp = 0;
    int   nerr = 0;
    bit   aborted = 1'b0;
    exp_t sb[$];

    seq_divider_if #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) bus ();

    seq_divider #(.WIDTH_IN(WI), .WIDTH_OUT(WO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [WI-1:0] a, input logic [WI-1:0] b);
        exp_t e;
        longint unsigned qq, rr;
        if (b == 0) begin
            qq = (64'd1 << WI) - 1;
            rr = a;
        end else begin
            qq = a / b;
            rr = a % b;
        end
        e.d0 = (b == 0);
        e.ov = (qq > 65535);
        e.q  = e.ov ? 16'hFFFF : qq[WO-1:0];
        e.r  = rr[WI-1:0];
        e.rcyc = 0;
        return e;
    endfunction

    // Called at a negedge; leaves the bench at the negedge after the accepting edge.
    task automatic issue(input logic [WI-1:0] a, input logic [WI-1:0] b);
        exp_t e;
        e = model(a, b);
        e.rcyc = cyc + 1 + LAT;
        bus.start = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = WI'($urandom);
        bus.divisor = WI'($urandom);
        chk("accept_busy", 32'(bus.Busy), 32'd1);
        chk("accept_ready", 32'(bus.Ready), 32'd0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < LAT + 10; i++) begin
            if (bus.Ready) break;
            @(negedge clk);
        end
        if (!bus.Ready) chk("ready_timeout", 32'(bus.Ready), 32'd1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_q"},  32'(bus.quotient), 32'd0);
        chk({nm, "_r"},  32'(bus.remainder), 32'd0);
        chk({nm, "_bsy"}, 32'(bus.Busy), 32'd0);
        chk({nm, "_rdy"}, 32'(bus.Ready), 32'd0);
        chk({nm, "_d0"}, 32'(bus.div0), 32'd0);
        chk({nm, "_ov"}, 32'(bus.ovf), 32'd0);
    endtask

    // Monitor: pops the scoreboard on each Ready rise, checks Busy pulse widths.
    initial begin
        bit rdy_q = 1'b0;
        bit bsy_q = 1'b0;
        int blen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.Busy) blen++;
            if (bsy_q && !bus.Busy) begin
                if (aborted) aborted = 1'b0;
                else begin
                    chk("busy_width", 32'(blen), 32'(LAT));
                    chk("ready_after_busy", 32'(bus.Ready), 32'd1);
                end
                blen = 0;
            end
            if (bus.Ready && !rdy_q) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("quotient", 32'(bus.quotient), 32'(e.q));
                    chk("remainder", 32'(bus.remainder), 32'(e.r));
                    chk("div0", 32'(bus.div0), 32'(e.d0));
                    chk("ovf", 32'(bus.ovf), 32'(e.ov));
                    chk("latency", 32'(cyc), 32'(e.rcyc));
                    chk("busy_and_ready", 32'(bus.Busy), 32'd0);
                end
            end
            rdy_q = bus.Ready;
            bsy_q = bus.Busy;
        end
    end

    initial begin
        logic [WI-1:0] a, b;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        issue(26'd15482, 26'd500);
        wait_done();
        repeat (5) @(negedge clk);
        chk("ready_hold", 32'(bus.Ready), 32'd1);
        chk("hold_q", 32'(bus.quotient), 32'd30);

        issue(26'd100000, 26'd1);
        wait_done();
        issue(26'd12345, 26'd0);
        wait_done();

        // start with new operands mid-RUN must be ignored
        issue(26'd1000, 26'd7);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.dividend = 26'd999999;
        bus.divisor = 26'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();

        // back-to-back from DONE without idle
        issue(26'd0, 26'd7);
        wait_done();
        repeat (8) @(negedge clk);
        chk("ready_hold2", 32'(bus.Ready), 32'd1);

        // reset in the middle of an iteration
        issue(26'd54321, 26'd11);
        repeat (9) @(negedge clk);
        aborted = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_back());
        chk_zero("midreset");
        issue(26'd15482, 26'd500);
        wait_done();

        for (int n = 0; n < 40; n++) begin
            int sel;
            sel = $urandom_range(0, 9);
            a = WI'($urandom) >> $urandom_range(0, 12);
            if (sel == 0)      b = '0;
            else if (sel < 5)  b = WI'($urandom_range(1, 255));
            else               b = WI'($urandom) >> $urandom_range(0, 20);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(a, b);
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
